// File: rtl/lc3b_types.sv
// Shared types and helpers for the LC-3b branch predictor slice.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam logic [3:0] op_br = 4'b0000;

  // Only BR with at least one condition bit set trains the predictor.
  function automatic logic is_cond_branch(input lc3b_word ir);
    return (ir[15:12] == op_br) && (ir[11:9] != 3'b000);
  endfunction

  // Saturating up/down step; max_val is the all-ones value for the caller's counter width.
  function automatic logic [3:0] sat_next(input logic [3:0] ctr, input logic taken,
                                          input logic [3:0] max_val);
    if (taken) return (ctr == max_val) ? ctr : ctr + 4'd1;
    return (ctr == 4'd0) ? ctr : ctr - 4'd1;
  endfunction

endpackage

// File: rtl/lc3b_branch_predictor_if.sv
// Fetch-lookup and resolve-update signals between the pipeline and the predictor.
interface lc3b_branch_predictor_if
  import lc3b_types::*;
#(
  parameter int unsigned GHR_W = 1
);
  lc3b_word           fetch_pc;
  logic               hit;
  logic               predict_taken;
  lc3b_word           predict_target;
  logic [GHR_W-1:0]   pred_ghr;
  logic               upd_valid;
  logic               stall;
  lc3b_word           upd_pc;
  lc3b_word           upd_ir;
  logic               upd_taken;
  lc3b_word           upd_target;
  logic [GHR_W-1:0]   upd_ghr;

  modport master (
    output fetch_pc, upd_valid, stall, upd_pc, upd_ir, upd_taken, upd_target, upd_ghr,
    input  hit, predict_taken, predict_target, pred_ghr
  );

  modport slave (
    input  fetch_pc, upd_valid, stall, upd_pc, upd_ir, upd_taken, upd_target, upd_ghr,
    output hit, predict_taken, predict_target, pred_ghr
  );
endinterface

// File: rtl/bp_counter_table.sv
// Direction counter array: async read port, synchronous saturating/allocating write port.
module bp_counter_table
  import lc3b_types::*;
#(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0]   rd_ctr,
  input  logic                  wr_en,
  input  logic                  wr_alloc,
  input  logic                  wr_taken,
  input  logic [INDEX_BITS-1:0] wr_idx
);
  localparam int unsigned         ENTRIES  = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] WEAK_NT  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] WEAK_T   = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [3:0]          CTR_MAX  = 4'((1 << CTR_BITS) - 1);

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] wr_val;

  assign rd_ctr = ctr_q[rd_idx];

  // New entries start weak in the resolved direction; existing ones step by one.
  always_comb begin
    wr_val = WEAK_NT;
    if (wr_alloc) wr_val = wr_taken ? WEAK_T : WEAK_NT;
    else          wr_val = CTR_BITS'(sat_next(4'(ctr_q[wr_idx]), wr_taken, CTR_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WEAK_NT;
    end else if (wr_en) begin
      ctr_q[wr_idx] <= wr_val;
    end
  end
endmodule

// File: rtl/lc3b_branch_predictor.sv
// BTB plus bimodal/gshare direction predictor; zero-latency lookup, one resolve update per cycle.
module lc3b_branch_predictor
  import lc3b_types::*;
#(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned GHR_BITS   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  lc3b_branch_predictor_if.slave bp
);
  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = 15 - INDEX_BITS;
  localparam int unsigned GHR_W   = (GHR_BITS > 0) ? GHR_BITS : 1;

  logic                  valid_q  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  lc3b_word              target_q [ENTRIES];
  logic [GHR_W-1:0]      ghr_q;

  logic [INDEX_BITS-1:0] f_idx, u_idx, f_ctr_idx, u_ctr_idx;
  logic [TAG_W-1:0]      f_tag, u_tag;
  logic [CTR_BITS-1:0]   f_ctr;
  logic                  f_hit, u_hit, upd_fire;
  logic                  unused_bits;

  assign f_idx = bp.fetch_pc[INDEX_BITS:1];
  assign f_tag = bp.fetch_pc[15:INDEX_BITS+1];
  assign u_idx = bp.upd_pc[INDEX_BITS:1];
  assign u_tag = bp.upd_pc[15:INDEX_BITS+1];
  assign unused_bits = ^{bp.fetch_pc[0], bp.upd_pc[0], bp.upd_ghr};

  assign upd_fire = bp.upd_valid && !bp.stall && !reset && is_cond_branch(bp.upd_ir);
  assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Reset gates hit so the reset cycle itself never predicts from stale entries.
  assign f_hit             = !reset && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign bp.hit            = f_hit;
  assign bp.predict_taken  = f_hit && f_ctr[CTR_BITS-1];
  assign bp.predict_target = target_q[f_idx];
  assign bp.pred_ghr       = ghr_q;

  // Training indexes with the history the fetch saw (upd_ghr), not the live register.
  if (GHR_BITS > 0) begin : g_gshare
    assign f_ctr_idx = f_idx ^ INDEX_BITS'(ghr_q);
    assign u_ctr_idx = u_idx ^ INDEX_BITS'(bp.upd_ghr);
    always_ff @(posedge clk) begin
      if (reset) ghr_q <= '0;
      else if (upd_fire) begin
        if (GHR_BITS == 1) ghr_q <= GHR_W'(bp.upd_taken);
        else               ghr_q <= GHR_W'({ghr_q, bp.upd_taken});
      end
    end
  end else begin : g_bimodal
    assign f_ctr_idx = f_idx;
    assign u_ctr_idx = u_idx;
    assign ghr_q     = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_fire) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: valid qualifies them.
  always_ff @(posedge clk) begin
    if (upd_fire) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= bp.upd_target;
    end
  end

  bp_counter_table #(
    .INDEX_BITS(INDEX_BITS),
    .CTR_BITS  (CTR_BITS)
  ) u_ctr (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (f_ctr_idx),
    .rd_ctr  (f_ctr),
    .wr_en   (upd_fire),
    .wr_alloc(!u_hit),
    .wr_taken(bp.upd_taken),
    .wr_idx  (u_ctr_idx)
  );
endmodule

// File: tb/tb_lc3b_branch_predictor.sv
// Bimodal and GHR_BITS=2 predictors driven in lockstep and checked against a behavioural model.
module tb_lc3b_branch_predictor;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lc3b_branch_predictor_if #(.GHR_W(1)) bpa ();
  lc3b_branch_predictor_if #(.GHR_W(2)) bpb ();

  lc3b_branch_predictor #(.INDEX_BITS(3), .CTR_BITS(2), .GHR_BITS(0)) dut_a (
    .clk(clk), .reset(reset), .bp(bpa));
  lc3b_branch_predictor #(.INDEX_BITS(3), .CTR_BITS(2), .GHR_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .bp(bpb));

  // Model: d=0 bimodal, d=1 gshare with 2 history bits; counters are plain ints 0..3.
  int m_valid [2][8];
  int m_tag   [2][8];
  int m_tgt   [2][8];
  int m_ctr   [2][8];
  int m_ghr   [2];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_check(input int d, input logic [15:0] fpc, input logic rst);
    int bidx, tg, cidx;
    logic eh, et;
    logic [15:0] oh, ot, otg, og;
    bidx = int'(fpc[3:1]);
    tg   = int'(fpc[15:4]);
    cidx = (d == 1) ? (bidx ^ m_ghr[d]) : bidx;
    eh   = !rst && (m_valid[d][bidx] != 0) && (m_tag[d][bidx] == tg);
    et   = eh && (m_ctr[d][cidx] >= 2);
    if (d == 0) begin
      oh = 16'(bpa.hit); ot = 16'(bpa.predict_taken); otg = bpa.predict_target; og = 16'(bpa.pred_ghr);
    end else begin
      oh = 16'(bpb.hit); ot = 16'(bpb.predict_taken); otg = bpb.predict_target; og = 16'(bpb.pred_ghr);
    end
    chk($sformatf("d%0d hit pc=%h", d, fpc), oh, 16'(eh));
    chk($sformatf("d%0d taken pc=%h", d, fpc), ot, 16'(et));
    if (eh) chk($sformatf("d%0d target pc=%h", d, fpc), otg, 16'(m_tgt[d][bidx]));
    if (!rst) chk($sformatf("d%0d ghr", d), og, 16'(m_ghr[d]));
  endtask

  task automatic model_update(input int d, input logic rst, input logic uv, input logic st,
                              input logic [15:0] upc, input logic [15:0] uir, input logic ut,
                              input logic [15:0] utg, input logic [1:0] ughr);
    int bidx, tg, cidx;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_valid[d][i] = 0; m_ctr[d][i] = 1; end
      m_ghr[d] = 0;
    end else if (uv && !st && uir[15:12] == 4'd0 && uir[11:9] != 3'd0) begin
      bidx = int'(upc[3:1]);
      tg   = int'(upc[15:4]);
      cidx = (d == 1) ? (bidx ^ int'(ughr)) : bidx;
      if (m_valid[d][bidx] != 0 && m_tag[d][bidx] == tg) begin
        if (ut) m_ctr[d][cidx] = (m_ctr[d][cidx] == 3) ? 3 : m_ctr[d][cidx] + 1;
        else    m_ctr[d][cidx] = (m_ctr[d][cidx] == 0) ? 0 : m_ctr[d][cidx] - 1;
      end else begin
        m_valid[d][bidx] = 1;
        m_tag[d][bidx]   = tg;
        m_ctr[d][cidx]   = ut ? 2 : 1;
      end
      m_tgt[d][bidx] = int'(utg);
      if (d == 1) m_ghr[d] = ((m_ghr[d] << 1) | int'(ut)) & 3;
    end
  endtask

  task automatic drive(input logic [15:0] fpc, input logic rst, input logic uv, input logic st,
                       input logic [15:0] upc, input logic [15:0] uir, input logic ut,
                       input logic [15:0] utg, input logic [1:0] ughr);
    reset = rst;
    bpa.fetch_pc = fpc;  bpb.fetch_pc = fpc;
    bpa.upd_valid = uv;  bpb.upd_valid = uv;
    bpa.stall = st;      bpb.stall = st;
    bpa.upd_pc = upc;    bpb.upd_pc = upc;
    bpa.upd_ir = uir;    bpb.upd_ir = uir;
    bpa.upd_taken = ut;  bpb.upd_taken = ut;
    bpa.upd_target = utg; bpb.upd_target = utg;
    bpa.upd_ghr = 1'b0;  bpb.upd_ghr = ughr;
  endtask

  // One clock: drive, check lookup mid-cycle, clock, advance the model.
  task automatic cycle(input logic [15:0] fpc, input logic rst, input logic uv, input logic st,
                       input logic [15:0] upc, input logic [15:0] uir, input logic ut,
                       input logic [15:0] utg, input logic [1:0] ughr);
    drive(fpc, rst, uv, st, upc, uir, ut, utg, ughr);
    @(negedge clk);
    model_check(0, fpc, rst);
    model_check(1, fpc, rst);
    @(posedge clk);
    #1;
    model_update(0, rst, uv, st, upc, uir, ut, utg, 2'b00);
    model_update(1, rst, uv, st, upc, uir, ut, utg, ughr);
  endtask

  task automatic upd_g(input logic [15:0] pc, input logic [15:0] ir, input logic t,
                       input logic [15:0] tgt, input logic [1:0] ughr);
    cycle(16'h3000, 1'b0, 1'b1, 1'b0, pc, ir, t, tgt, ughr);
  endtask

  task automatic upd(input logic [15:0] pc, input logic [15:0] ir, input logic t,
                     input logic [15:0] tgt);
    upd_g(pc, ir, t, tgt, 2'(m_ghr[1]));
  endtask

  // Idle lookup with hand-written expectations alongside the model.
  task automatic look(input logic [15:0] fpc, input logic eh, input logic et_a,
                      input logic [15:0] etgt, input logic [1:0] eghr_b);
    drive(fpc, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'b00);
    @(negedge clk);
    model_check(0, fpc, 1'b0);
    model_check(1, fpc, 1'b0);
    chk($sformatf("const a hit %h", fpc), 16'(bpa.hit), 16'(eh));
    chk($sformatf("const b hit %h", fpc), 16'(bpb.hit), 16'(eh));
    chk($sformatf("const a taken %h", fpc), 16'(bpa.predict_taken), 16'(et_a));
    chk($sformatf("const b ghr %h", fpc), 16'(bpb.pred_ghr), 16'(eghr_b));
    if (eh) begin
      chk($sformatf("const a target %h", fpc), bpa.predict_target, etgt);
      chk($sformatf("const b target %h", fpc), bpb.predict_target, etgt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and empty lookup
    cycle(16'h3000, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 2'b00);
    cycle(16'h3000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 2'b00);
    look(16'h3000, 1'b0, 1'b0, 16'h0, 2'b00);

    // First allocation (gshare history shifts 00->01)
    upd(16'h3006, 16'h0E05, 1'b1, 16'h3012);
    look(16'h3006, 1'b1, 1'b1, 16'h3012, 2'b01);
    look(16'h3016, 1'b0, 1'b0, 16'h0, 2'b01);

    // Saturation on the bimodal counter: 10->01->00->00, then up to 11 and back to 10
    upd(16'h3006, 16'h0E05, 1'b0, 16'h3012);
    look(16'h3006, 1'b1, 1'b0, 16'h3012, 2'b10);
    upd(16'h3006, 16'h0E05, 1'b0, 16'h3012);
    upd(16'h3006, 16'h0E05, 1'b0, 16'h3012);
    upd(16'h3006, 16'h0E05, 1'b1, 16'h3012);
    look(16'h3006, 1'b1, 1'b0, 16'h3012, 2'b01);
    upd(16'h3006, 16'h0E05, 1'b1, 16'h3012);
    look(16'h3006, 1'b1, 1'b1, 16'h3012, 2'b11);
    upd(16'h3006, 16'h0E05, 1'b1, 16'h3012);
    upd(16'h3006, 16'h0E05, 1'b1, 16'h3012);
    upd(16'h3006, 16'h0E05, 1'b0, 16'h3012);
    look(16'h3006, 1'b1, 1'b1, 16'h3012, 2'b10);

    // Target rewrite on hit, then aliasing replacement
    upd(16'h3006, 16'h0E05, 1'b1, 16'h3020);
    look(16'h3006, 1'b1, 1'b1, 16'h3020, 2'b01);
    upd(16'h3016, 16'h0E05, 1'b1, 16'h3040);
    look(16'h3006, 1'b0, 1'b0, 16'h0, 2'b11);
    look(16'h3016, 1'b1, 1'b1, 16'h3040, 2'b11);

    // Non-trainable instructions and stall leave everything untouched
    upd(16'h3016, 16'h1021, 1'b0, 16'h1111);
    upd(16'h3016, 16'h0005, 1'b0, 16'h2222);
    cycle(16'h3016, 1'b0, 1'b1, 1'b1, 16'h3016, 16'h0E05, 1'b0, 16'h2222, 2'b11);
    cycle(16'h3016, 1'b0, 1'b1, 1'b1, 16'h3016, 16'h0E05, 1'b0, 16'h2222, 2'b11);
    look(16'h3016, 1'b1, 1'b1, 16'h3040, 2'b11);
    upd(16'h3000, 16'h0402, 1'b1, 16'h3100);
    look(16'h3000, 1'b1, 1'b1, 16'h3100, 2'b11);

    // Reset with an update pending discards it and clears the BTB
    cycle(16'h3000, 1'b1, 1'b1, 1'b0, 16'h3002, 16'h0E05, 1'b1, 16'h3200, 2'b00);
    look(16'h3002, 1'b0, 1'b0, 16'h0, 2'b00);
    look(16'h3000, 1'b0, 1'b0, 16'h0, 2'b00);

    // Gshare: history 00->01->11; training honours upd_ghr rather than live history
    upd(16'h3006, 16'h0E05, 1'b1, 16'h3012);
    look(16'h3006, 1'b1, 1'b1, 16'h3012, 2'b01);
    upd(16'h3006, 16'h0E05, 1'b1, 16'h3012);
    look(16'h3006, 1'b1, 1'b1, 16'h3012, 2'b11);
    upd_g(16'h3006, 16'h0E05, 1'b0, 16'h3012, 2'b01);
    upd_g(16'h3006, 16'h0E05, 1'b1, 16'h3012, 2'b10);
    look(16'h3006, 1'b1, 1'b1, 16'h3012, 2'b01);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [15:0] fp, up, ir;
      int k;
      fp = 16'h3000 + 16'(2 * $urandom_range(0, 15)) + 16'(256 * $urandom_range(0, 1));
      up = 16'h3000 + 16'(2 * $urandom_range(0, 15)) + 16'(256 * $urandom_range(0, 1));
      k  = int'($urandom_range(0, 5));
      case (k)
        3:       ir = 16'h1021;
        4:       ir = {7'b0000000, 9'($urandom)};
        5:       ir = 16'($urandom);
        default: ir = {4'b0000, 3'($urandom_range(1, 7)), 9'($urandom)};
      endcase
      cycle(fp, $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            up, ir, 1'($urandom), 16'($urandom),
            ($urandom_range(0, 1) == 1) ? 2'(m_ghr[1]) : 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lc3b_branch_predictor.md
Name: lc3b_branch_predictor

Overview:
- Parametrised branch target buffer plus direction predictor for the pipelined LC-3b core.
- Fetch stage looks it up every cycle. It returns hit, predicted direction, target, and a history snapshot.
- Execute/resolve stage trains it with the resolved branch outcome.
- Adds over the first generation: reset, valid bits, full-tag compare, configurable depth and counter width, optional gshare indexing, and a resolve-time history checkpoint.

Parameters:
- INDEX_BITS, 3, log2 of BTB entries; index = pc[INDEX_BITS:1]; tag = pc[15:INDEX_BITS+1].
- CTR_BITS, 2, saturating counter width (1..4).
- GHR_BITS, 0, global history length; 0 = bimodal; legal range 0..INDEX_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- fetch_pc  in  16  PC being fetched.
- hit  out  1  valid entry with matching tag.
- predict_taken  out  1  hit && counter MSB.
- predict_target  out  16  stored target (don't-care when hit=0).
- pred_ghr  out  max(GHR_BITS,1)  GHR value used for this lookup; pipeline carries it to resolve.
- upd_valid  in  1  resolve stage presents a branch outcome.
- stall  in  1  pipeline stall; blocks all state updates.
- upd_pc  in  16  PC of resolved instruction.
- upd_ir  in  16  its instruction word.
- upd_taken  in  1  actual direction.
- upd_target  in  16  computed target.
- upd_ghr  in  max(GHR_BITS,1)  pred_ghr returned from fetch.

Behaviour:
- State (flop arrays, 2^INDEX_BITS entries):
  - per entry: valid, tag, target.
  - counter table: 2^INDEX_BITS counters.
  - GHR register, GHR_BITS wide.
- Reset: all valid=0; all counters = weakly-not-taken (MSB 0, rest 1, e.g. 01 for CTR_BITS=2); GHR=0.
  - Outputs in the reset cycle and the cycle after: hit=0, predict_taken=0.
  - Reset asserted mid-training discards the pending update.
- Lookup (combinational from registered state, zero latency):
  - BTB index = fetch_pc[INDEX_BITS:1].
  - Counter index = BTB index XOR {zero-extended GHR} when GHR_BITS>0, otherwise the BTB index.
  - pred_ghr = current GHR.
- Trainable instruction: upd_ir[15:12]==0000 && upd_ir[11:9]!=000. Anything else is ignored entirely, including GHR.
- Update fires on the rising edge when upd_valid && !stall && !reset && trainable. It uses upd_ghr for the counter index, never the live GHR.
  - Hit (valid && tag match): counter saturating +1 if taken, -1 if not taken. Saturation: no wrap past all-ones or zero. Target rewritten with upd_target if it differs.
  - Miss: allocate (overwrite) the entry with valid=1, tag, target. Counter initialised to weakly-taken (10..0) if taken, weakly-not-taken (01..1) if not taken.
  - GHR <= {GHR[GHR_BITS-2:0], upd_taken} when GHR_BITS>0.
- Simultaneous lookup and update to the same entry: lookup returns pre-update contents; new state is visible the next cycle. No bypass.
- stall=1 freezes all state. Lookup outputs still follow fetch_pc.
- Single update per cycle; no backpressure; no output registers.

Decomposition:
- lc3b_types package holds:
  - lc3b_word (16-bit);
  - constant op_br = 4'b0000;
  - function is_cond_branch(ir);
  - function sat_next(ctr, taken), parametrised by CTR_BITS via a localparam in the module.
- Natural sub-module: bp_counter_table. Holds the counter array, combinational read port, reset initialisation and saturating update write port.
- BTB tag/target/valid arrays stay in the top module.

Test Plan:
- Reset, then fetch_pc=0x3000 -> hit=0, predict_taken=0.
- Update pc=0x3006, ir=0x0E05 (BRnzp), taken=1, target=0x3012.
  - Next cycle fetch_pc=0x3006 -> hit=1, predict_taken=1, predict_target=0x3012.
  - fetch_pc=0x3016 (same index, tag 0x301) -> hit=0.
- Counter saturation (CTR_BITS=2, starting at counter 10):
  - Two not-taken updates to 0x3006 -> counter 10->01->00; predict_taken=0 after the first update.
  - Third not-taken update: counter stays 00.
  - Four taken updates: 00->01->10->11->11.
- Aliasing: taken update pc=0x3016, target 0x3040 replaces the entry -> fetch 0x3006 hit=0; fetch 0x3016 hit=1, target 0x3040.
- Filtering and freeze:
  - upd_ir=0x1021 (ADD) or 0x0005 (nzp=000) -> no state change, GHR unchanged.
  - stall=1 with a valid BR update -> no change.
  - reset asserted after training -> hit=0 next cycle.
- GHR_BITS=2:
  - Taken updates at 0x3006 shift GHR 00->01->11; pred_ghr tracks the shift.
  - Update with upd_ghr=01 trains counter index 011^01=010, not the live-GHR index.
